// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// master = sequencer, slave = datapath (IR, PC, regfile, ALU, memory).
interface multicycle_control_unit_if #(
    parameter int W_OP    = 6,
    parameter int W_STATE = 3
);
    logic [W_OP-1:0]    opcode;
    logic               zero;
    logic               mem_ready;
    logic [W_STATE-1:0] state;
    logic               pc_we;
    logic [1:0]         pc_src;
    logic               ir_we;
    logic               mem_rd;
    logic               mem_wr;
    logic               alu_src_b;
    logic [2:0]         alu_op;
    logic               reg_we;
    logic [1:0]         reg_dst;
    logic [1:0]         wb_sel;
    logic               halted;
    logic               illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output state, pc_we, pc_src, ir_we, mem_rd, mem_wr,
        output alu_src_b, alu_op, reg_we, reg_dst, wb_sel,
        output halted, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  state, pc_we, pc_src, ir_we, mem_rd, mem_wr,
        input  alu_src_b, alu_op, reg_we, reg_dst, wb_sel,
        input  halted, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU sequencer: registered state plus a sticky halt flag,
// all datapath controls decoded combinationally from state/opcode/flags.
module multicycle_control_unit #(
    parameter int W_OP    = 6,
    parameter int W_STATE = 3
) (
    input logic CLK,
    input logic Reset,
    multicycle_control_unit_if.master bus
);
    localparam logic [W_STATE-1:0] S_IF     = 3'b000;
    localparam logic [W_STATE-1:0] S_ID     = 3'b001;
    localparam logic [W_STATE-1:0] S_EXE_B  = 3'b101;
    localparam logic [W_STATE-1:0] S_EXE_AL = 3'b110;
    localparam logic [W_STATE-1:0] S_EXE_LS = 3'b010;
    localparam logic [W_STATE-1:0] S_MEM    = 3'b011;
    localparam logic [W_STATE-1:0] S_WB_AL  = 3'b111;
    localparam logic [W_STATE-1:0] S_WB_LD  = 3'b100;

    localparam logic [W_OP-1:0] OP_ADD  = 6'b000000;
    localparam logic [W_OP-1:0] OP_SUB  = 6'b000001;
    localparam logic [W_OP-1:0] OP_ADDI = 6'b000010;
    localparam logic [W_OP-1:0] OP_OR   = 6'b010000;
    localparam logic [W_OP-1:0] OP_AND  = 6'b010001;
    localparam logic [W_OP-1:0] OP_ORI  = 6'b010010;
    localparam logic [W_OP-1:0] OP_SLL  = 6'b011000;
    localparam logic [W_OP-1:0] OP_SLT  = 6'b100110;
    localparam logic [W_OP-1:0] OP_SW   = 6'b110000;
    localparam logic [W_OP-1:0] OP_LW   = 6'b110001;
    localparam logic [W_OP-1:0] OP_BEQ  = 6'b110100;
    localparam logic [W_OP-1:0] OP_J    = 6'b111000;
    localparam logic [W_OP-1:0] OP_JR   = 6'b111001;
    localparam logic [W_OP-1:0] OP_JAL  = 6'b111010;
    localparam logic [W_OP-1:0] OP_HALT = 6'b111111;

    logic [W_STATE-1:0] state;
    logic [W_STATE-1:0] next;
    logic               halted;

    logic [2:0] aop;
    logic imm, alu, ls, ld, br, jmp, jreg, link, hlt;

    always_comb begin
        aop  = 3'b000;
        imm  = 1'b0;
        alu  = 1'b0;
        ls   = 1'b0;
        ld   = 1'b0;
        br   = 1'b0;
        jmp  = 1'b0;
        jreg = 1'b0;
        link = 1'b0;
        hlt  = 1'b0;
        case (bus.opcode)
            OP_ADD:  alu = 1'b1;
            OP_SUB:  begin alu = 1'b1; aop = 3'b001; end
            OP_ADDI: begin alu = 1'b1; imm = 1'b1; end
            OP_OR:   begin alu = 1'b1; aop = 3'b010; end
            OP_AND:  begin alu = 1'b1; aop = 3'b011; end
            OP_ORI:  begin alu = 1'b1; aop = 3'b010; imm = 1'b1; end
            OP_SLL:  begin alu = 1'b1; aop = 3'b100; end
            OP_SLT:  begin alu = 1'b1; aop = 3'b101; end
            OP_SW:   ls = 1'b1;
            OP_LW:   begin ls = 1'b1; ld = 1'b1; end
            OP_BEQ:  br = 1'b1;
            OP_J:    jmp = 1'b1;
            OP_JR:   jreg = 1'b1;
            OP_JAL:  begin jmp = 1'b1; link = 1'b1; end
            OP_HALT: hlt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        next          = state;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'b00;
        bus.ir_we     = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 3'b000;
        bus.reg_we    = 1'b0;
        bus.reg_dst   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.illegal   = 1'b0;
        // Outputs stay quiet for the whole time Reset is held.
        if (!Reset) begin
            case (state)
                S_IF: begin
                    if (!halted) begin
                        bus.mem_rd = 1'b1;
                        if (bus.mem_ready) begin
                            bus.ir_we = 1'b1;
                            bus.pc_we = 1'b1;
                            next      = S_ID;
                        end
                    end
                end
                S_ID: begin
                    next = S_IF;
                    unique case (1'b1)
                        jmp: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'b10;
                            if (link) begin
                                bus.reg_we  = 1'b1;
                                bus.reg_dst = 2'b10;
                                bus.wb_sel  = 2'b10;
                            end
                        end
                        jreg: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 2'b11;
                        end
                        hlt: ;
                        br:  next = S_EXE_B;
                        ls:  next = S_EXE_LS;
                        alu: next = S_EXE_AL;
                        default: bus.illegal = 1'b1;
                    endcase
                end
                S_EXE_B: begin
                    bus.alu_op = 3'b001;
                    if (bus.zero) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'b01;
                    end
                    next = S_IF;
                end
                S_EXE_AL: begin
                    bus.alu_src_b = imm;
                    bus.alu_op    = aop;
                    next          = S_WB_AL;
                end
                S_WB_AL: begin
                    bus.alu_src_b = imm;
                    bus.alu_op    = aop;
                    bus.reg_we    = 1'b1;
                    bus.reg_dst   = imm ? 2'b00 : 2'b01;
                    next          = S_IF;
                end
                S_EXE_LS: begin
                    bus.alu_src_b = 1'b1;
                    next          = S_MEM;
                end
                S_MEM: begin
                    bus.alu_src_b = 1'b1;
                    bus.mem_rd    = ld;
                    bus.mem_wr    = !ld;
                    if (bus.mem_ready)
                        next = ld ? S_WB_LD : S_IF;
                end
                S_WB_LD: begin
                    bus.reg_we = 1'b1;
                    bus.wb_sel = 2'b01;
                    next       = S_IF;
                end
                default: next = S_IF;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= S_IF;
            halted <= 1'b0;
        end else begin
            state <= next;
            if (state == S_ID && hlt)
                halted <= 1'b1;
        end
    end

    assign bus.state  = state;
    assign bus.halted = halted;
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Sequencing controller for the multi-cycle CPU datapath. Holds the registered instruction state, advances it per opcode, and drives every per-cycle datapath enable and mux select.
- Adds wait states on the shared instruction/data memory via a ready handshake.
- Adds a sticky halt.
- Sits between the instruction register (opcode, ALU zero flag) and the PC, IR, register file, ALU and memory.

Parameters:
- W_OP, 6, opcode width.
- W_STATE, 3, state register width. Encoding is fixed below.

Ports:
- CLK  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high; clears state to IF.
- opcode  in  6  IR[31:26]; valid from ID onward, held stable by IR.
- zero  in  1  ALU zero flag, sampled in EXE_B.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- state  out  3  current state, for debug/LED.
- pc_we  out  1  PC load enable.
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr).
- ir_we  out  1  IR load enable.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- alu_src_b  out  1  0 rt, 1 extended immediate.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt.
- reg_we  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC (already +4).
- halted  out  1  sticky halt flag.
- illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- State encoding: IF 000, ID 001, EXE_B 101, EXE_AL 110, EXE_LS 010, MEM 011, WB_AL 111, WB_LD 100.
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010
  - sll 011000, slt 100110
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
- Reset, asynchronous and active-high:
  - state=IF, halted=0.
  - All enables and selects are 0.
  - Reset asserted mid-instruction abandons it; there is no partial writeback after release.
- All control outputs decode combinationally from the registered state, opcode, zero and mem_ready. Only state and halted are flops.
- IF: mem_rd=1.
  - If mem_ready=1: ir_we=1, pc_we=1, pc_src=00, next state ID.
  - If mem_ready=0: hold IF with ir_we=pc_we=0.
  - If halted=1: all outputs 0 and state holds IF.
- ID:
  - j: pc_we=1, pc_src=10, next IF.
  - jr: pc_we=1, pc_src=11, next IF.
  - jal: pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wb_sel=10, next IF.
  - halt: halted<=1, next IF, no pc_we.
  - beq: next EXE_B.
  - sw/lw: next EXE_LS.
  - ALU ops: next EXE_AL.
  - Undefined opcode: illegal=1 for this cycle, next IF; nothing is written, and the PC has already advanced.
- EXE_B: alu_op=001, alu_src_b=0. If zero=1: pc_we=1, pc_src=01. Next IF.
- EXE_AL:
  - alu_src_b=1 for addi/ori, 0 otherwise.
  - alu_op per opcode; addi→add, ori→or.
  - Next WB_AL.
- WB_AL: reg_we=1, wb_sel=00; reg_dst=00 for addi/ori, 01 otherwise. alu_op and alu_src_b are held from EXE_AL. Next IF.
- EXE_LS: alu_op=000, alu_src_b=1. Next MEM.
- MEM:
  - alu_op=000 and alu_src_b=1 are held.
  - lw: mem_rd=1. sw: mem_wr=1.
  - Stay in MEM while mem_ready=0.
  - On mem_ready=1: lw→WB_LD, sw→IF.
- WB_LD: reg_we=1, reg_dst=00, wb_sel=01. Next IF.
- Unreachable state codes: none exist, since all 8 codes are used. Default branch goes to IF.
- Latency with mem_ready tied 1:
  - j/jr/jal/halt: 2 cycles.
  - beq: 3 cycles.
  - ALU ops and sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle in IF or MEM adds one cycle.
- mem_rd and mem_wr are never both 1. reg_we and mem_wr are never both 1.
- Only Reset clears halted.

Test Plan:
- Reset asserted asynchronously mid-MEM of sw (mem_wr=1) → state=000 and mem_wr=0 in the same cycle, with no clock edge needed. After release, IF mem_rd=1.
- add (000000), mem_ready=1 → states 000,001,110,111,000. reg_we=1 only in 111, with reg_dst=01, wb_sel=00.
- lw (110001) with mem_ready low for 2 cycles in MEM → 000,001,010,011,011,011,100,000. mem_rd=1 throughout MEM; reg_we=1, wb_sel=01 in 100.
- beq with zero=1 → pc_we=1, pc_src=01 in state 101. Repeat with zero=0 → pc_we=0. Both return to 000 after 3 cycles.
- jal (111010) → in 001: pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wb_sel=10; next 000. Opcode 101010 → illegal pulses once in 001, no reg_we.
- halt (111111) → halted=1 from the next cycle. State stays 000 with mem_rd, ir_we and pc_we all 0 for 10+ cycles; Reset clears halted.
